serial_operand_serializer: RTL and testbench

//  Upstream feeder for the bit-serial adder.
//  - Accepts two W-bit operands through a valid/ready handshake.
//  - Streams them out LSB-first as bit pairs (a, b), one pair per clock.
//  - Drives carry_clr, which connects to the adder's synchronous reset, so

---
 rtl/serial_pkg.sv | 12 +
 rtl/serial_operand_serializer.sv | 69 ++++++
 tb/tb_serial_operand_serializer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial operand feeder and its downstream sum collector.
package serial_pkg;

  localparam int DEFAULT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/serial_operand_serializer.sv
// Loads two W-bit operands over valid/ready and streams them LSB-first as bit pairs,
// with word framing sideband and a carry-clear strobe for the downstream serial adder.
module serial_operand_serializer
  import serial_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int CNT_W = (W == 1) ? 1 : $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         a,
  output logic         b,
  output logic         bit_valid,
  output logic         first_bit,
  output logic         last_bit,
  output logic         carry_clr
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(W - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_shA;
  logic [W-1:0]     r_shB;
  logic             w_lastBit;
  logic             w_xfer;

  // Accepting on the last bit lets words run back-to-back with a single CLEAR cycle between them.
  assign w_lastBit = (r_state == SHIFT) && (r_cnt == LAST_IDX);
  assign in_ready  = (r_state == IDLE) || w_lastBit;
  assign w_xfer    = in_valid && in_ready;

  assign bit_valid = (r_state == SHIFT);
  assign carry_clr = (r_state != SHIFT);
  assign a         = bit_valid && r_shA[0];
  assign b         = bit_valid && r_shB[0];
  assign first_bit = bit_valid && (r_cnt == '0);
  assign last_bit  = w_lastBit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shA   <= '0;
      r_shB   <= '0;
    end else if (w_xfer) begin
      r_shA   <= in_a;
      r_shB   <= in_b;
      r_cnt   <= '0;
      r_state <= CLEAR;
    end else begin
      case (r_state)
        CLEAR: r_state <= SHIFT;
        SHIFT: begin
          r_shA <= r_shA >> 1;
          r_shB <= r_shB >> 1;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_lastBit) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and a
// randomized run against a word-level (a+b mod 2^W) reference with a model serial adder.
module tb_serial_operand_serializer;
  import serial_pkg::*;

  localparam int W = DEFAULT_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         inValid;
  logic         inReady;
  logic [W-1:0] inA;
  logic [W-1:0] inB;
  logic         a, b, bitValid, firstBit, lastBit, carryClr;

  logic         inValid1;
  logic         inReady1;
  logic [0:0]   inA1;
  logic [0:0]   inB1;
  logic         a1, b1, bitValid1, firstBit1, lastBit1, carryClr1;

  always #5 clk = ~clk;

  serial_operand_serializer #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
    .in_a(inA), .in_b(inB), .a(a), .b(b), .bit_valid(bitValid),
    .first_bit(firstBit), .last_bit(lastBit), .carry_clr(carryClr)
  );

  serial_operand_serializer #(.W(1)) dutW1 (
    .clk(clk), .rst(rst), .in_valid(inValid1), .in_ready(inReady1),
    .in_a(inA1), .in_b(inB1), .a(a1), .b(b1), .bit_valid(bitValid1),
    .first_bit(firstBit1), .last_bit(lastBit1), .carry_clr(carryClr1)
  );

  int nChecks = 0;
  int nFails  = 0;

  // Downstream serial adder with carry_clr as its synchronous reset, plus a word collector.
  logic         carry  = 1'b0;
  logic         carry1 = 1'b0;
  logic         sumBit, sumBit1;
  logic [W-1:0] acc = '0;
  logic [W-1:0] gotQ[$];
  logic [W-1:0] expQ[$];
  int           violations = 0;

  assign sumBit  = a ^ b ^ carry;
  assign sumBit1 = a1 ^ b1 ^ carry1;

  always @(posedge clk) begin
    carry  <= carryClr  ? 1'b0 : ((a & b) | (carry & (a ^ b)));
    carry1 <= carryClr1 ? 1'b0 : ((a1 & b1) | (carry1 & (a1 ^ b1)));
    if (bitValid) begin
      acc <= {sumBit, acc[W-1:1]};
      if (lastBit) gotQ.push_back({sumBit, acc[W-1:1]});
    end
    if ((bitValid && carryClr) || (bitValid1 && carryClr1)) violations <= violations + 1;
  end

  typedef struct {
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic [W-1:0] expSum;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkIdle(input string name);
    checkOutput({name, ".inReady"},  inReady,  1);
    checkOutput({name, ".bitValid"}, bitValid, 0);
    checkOutput({name, ".carryClr"}, carryClr, 1);
    checkOutput({name, ".ab"},       {a, b},   0);
    checkOutput({name, ".frame"},    {firstBit, lastBit}, 0);
  endtask

  task automatic checkClear(input string name);
    checkOutput({name, ".inReady"},  inReady,  0);
    checkOutput({name, ".bitValid"}, bitValid, 0);
    checkOutput({name, ".carryClr"}, carryClr, 1);
    checkOutput({name, ".ab"},       {a, b},   0);
  endtask

  task automatic checkBit(input string name, input logic [W-1:0] opA, input logic [W-1:0] opB,
                          input int idx);
    checkOutput($sformatf("%s.bit%0d.ab", name, idx), {a, b}, {opA[idx], opB[idx]});
    checkOutput($sformatf("%s.bit%0d.valid", name, idx), {bitValid, carryClr}, 2'b10);
    checkOutput($sformatf("%s.bit%0d.frame", name, idx), {firstBit, lastBit},
                {idx == 0, idx == W - 1});
    checkOutput($sformatf("%s.bit%0d.inReady", name, idx), inReady, idx == W - 1);
  endtask

  task automatic checkWord(input string name, input logic [W-1:0] expSum);
    if (gotQ.size() == 0) begin
      checkOutput({name, ".wordPresent"}, 0, 1);
    end else begin
      checkOutput({name, ".sum"}, gotQ.pop_front(), expSum);
    end
  endtask

  // One isolated word from IDLE through CLEAR, W bits and back to IDLE.
  task automatic applyStimulus(input string name, input logic [W-1:0] opA,
                               input logic [W-1:0] opB, input logic [W-1:0] expSum);
    @(negedge clk);
    inValid = 1'b1; inA = opA; inB = opB;
    checkOutput({name, ".readyIdle"}, inReady, 1);
    @(negedge clk);
    inValid = 1'b0;
    checkClear({name, ".clear"});
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      checkBit(name, opA, opB, i);
    end
    @(negedge clk);
    checkIdle({name, ".idle"});
    checkWord(name, expSum);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [W-1:0] opA, opB;
    int sent, cyc, s;

    vecs[0] = '{8'h5A, 8'h33, 8'h8D};
    vecs[1] = '{8'hFF, 8'h01, 8'h00};
    vecs[2] = '{8'h80, 8'h80, 8'h00};
    vecs[3] = '{8'h7F, 8'h01, 8'h80};
    vecs[4] = '{8'h00, 8'h00, 8'h00};

    rst = 1'b1; inValid = 1'b0; inA = '0; inB = '0;
    inValid1 = 1'b0; inA1 = '0; inB1 = '0;
    repeat (2) @(negedge clk);
    checkIdle("reset");
    checkOutput("resetW1", {inReady1, bitValid1, carryClr1}, 3'b101);
    rst = 1'b0;

    for (int v = 0; v < 5; v++)
      applyStimulus($sformatf("vec%0d", v), vecs[v].opA, vecs[v].opB, vecs[v].expSum);

    // Back-to-back: second word offered on the last bit of the first.
    opA = 8'hFF; opB = 8'h01;
    @(negedge clk); inValid = 1'b1; inA = opA; inB = opB;
    @(negedge clk); inValid = 1'b0;
    checkClear("b2b.clear1");
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      checkBit("b2b.w1", opA, opB, i);
      if (i == W - 1) begin inValid = 1'b1; inA = 8'h00; inB = 8'h00; end
    end
    @(negedge clk); inValid = 1'b0;
    checkClear("b2b.clear2");
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      checkBit("b2b.w2", 8'h00, 8'h00, i);
    end
    @(negedge clk);
    checkIdle("b2b.idle");
    checkWord("b2b.w1", 8'h00);
    checkWord("b2b.w2", 8'h00);

    // in_valid held with changing data while busy.
    opA = 8'hC3; opB = 8'h3C;
    @(negedge clk); inValid = 1'b1; inA = opA; inB = opB;
    @(negedge clk); inA = W'($urandom); inB = W'($urandom);
    checkClear("hold.clear");
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      checkBit("hold", opA, opB, i);
      if (i < W - 1) begin inA = W'($urandom); inB = W'($urandom); end
      else inValid = 1'b0;
    end
    @(negedge clk);
    checkIdle("hold.idle");
    checkWord("hold", 8'hFF);

    // Reset at bit index 3 discards the word.
    opA = 8'hA5; opB = 8'h5A;
    @(negedge clk); inValid = 1'b1; inA = opA; inB = opB;
    @(negedge clk); inValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkBit("rstMid", opA, opB, i);
    end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checkIdle("rstMid.after");
    repeat (W) @(negedge clk);
    checkOutput("rstMid.noWord", gotQ.size(), 0);
    checkOutput("rstMid.stillIdle", {inReady, bitValid}, 2'b10);
    applyStimulus("postRst", 8'h01, 8'h01, 8'h02);

    // Reset and transfer on the same edge: reset wins.
    @(negedge clk); rst = 1'b1; inValid = 1'b1; inA = 8'h77; inB = 8'h11;
    @(negedge clk); rst = 1'b0; inValid = 1'b0;
    checkIdle("rstXfer.a");
    @(negedge clk);
    checkIdle("rstXfer.b");

    // W == 1 instance.
    @(negedge clk); inValid1 = 1'b1; inA1 = 1'b1; inB1 = 1'b1;
    checkOutput("w1.readyIdle", inReady1, 1);
    @(negedge clk); inValid1 = 1'b0;
    checkOutput("w1.clear", {inReady1, bitValid1, carryClr1}, 3'b001);
    @(negedge clk);
    checkOutput("w1.shift", {bitValid1, carryClr1, inReady1}, 3'b101);
    checkOutput("w1.frame", {firstBit1, lastBit1}, 2'b11);
    checkOutput("w1.ab", {a1, b1}, 2'b11);
    checkOutput("w1.sumBit", sumBit1, 0);
    @(negedge clk);
    checkOutput("w1.carryNext", carry1, 1);
    checkOutput("w1.idle", {inReady1, bitValid1, carryClr1}, 3'b101);

    // Randomized traffic with gaps against word-level arithmetic.
    gotQ.delete();
    expQ.delete();
    sent = 0;
    cyc  = 0;
    while (sent < 1000 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      inValid = ($urandom_range(0, 3) != 0);
      inA = W'($urandom);
      inB = W'($urandom);
      if (inValid && inReady) begin
        s = (int'(inA) + int'(inB)) % (1 << W);
        expQ.push_back(W'(s));
        sent++;
      end
    end
    @(negedge clk); inValid = 1'b0;
    checkOutput("rand.sent", sent, 1000);
    cyc = 0;
    while (gotQ.size() < expQ.size() && cyc < 4 * W) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("rand.count", gotQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
      checkOutput($sformatf("rand.word%0d", i), gotQ[i], expQ[i]);

    checkOutput("noBitWhileClr", violations, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
